// File: rtl/counter_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// counter_arb_pkg
// Shared types and constants for the counter_arbiter block: the FSM state
// encoding and default sizing for requesters, counter width and prescaler.
// No ports (package).
// ---------------------------------------------------------------------------
package counter_arb_pkg;

    localparam int STATE_W          = 2;
    localparam int DEFAULT_NREQ     = 4;
    localparam int DEFAULT_CW       = 4;
    localparam int DEFAULT_PRESCALE = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/counter_arbiter_if.sv
// ---------------------------------------------------------------------------
// counter_arbiter_if
// Request/grant bundle between the delay-requesting control FSMs and the
// shared interval timer.
//   req   [NREQ]     request level per requester
//   len   [NREQ*CW]  run length per requester, len[i*CW +: CW] for req[i]
//   grant [NREQ]     one-hot grant, zero when idle
//   done  [NREQ]     one-cycle completion pulse
//   busy             timer occupied (LOAD/RUN/DONE)
//   count [CW]       shared counter value
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface counter_arbiter_if
    import counter_arb_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int CW   = DEFAULT_CW
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      count;

    modport master (
        output req, len,
        input  grant, done, busy, count
    );

    modport slave (
        input  req, len,
        output grant, done, busy, count
    );
endinterface

// File: rtl/counter_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: finds the first set request at or after
// ptr, wrapping past NREQ-1 back to 0.
//   req    in  [NREQ]  request vector
//   ptr    in  [IW]    highest-priority index
//   onehot out [NREQ]  selected requester, one-hot (zero if none)
//   idx    out [IW]    selected requester index
//   found  out         at least one request present
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            found
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        // Segment [ptr .. NREQ-1] outranks the wrapped segment [0 .. ptr-1].
        for (int i = 0; i < NREQ; i++) begin
            if (!found && (i >= int'(ptr)) && req[i]) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && (i < int'(ptr)) && req[i]) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// ---------------------------------------------------------------------------
// counter_arbiter
// Shares one up-counting interval timer between NREQ requesters. Grants are
// round-robin; the granted requester's length is loaded, the counter runs
// count 0..len-1, and a one-cycle done pulse returns to that requester.
// Dropping the granted request during LOAD/RUN aborts without a done pulse.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   bus    counter_arbiter_if.slave (req, len in; grant, done, busy, count out)
// Optional feature macro: COUNTER_ARB_PRESCALE_EN -- when defined, the counter
// advances once every PRESCALE clocks instead of every clock.
// ---------------------------------------------------------------------------
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int NREQ     = DEFAULT_NREQ,
    parameter int CW       = DEFAULT_CW,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    counter_arbiter_if.slave bus
);

    localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q,  done_d;
    logic            busy_q,  busy_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   limit_q, limit_d;
    logic [IW-1:0]   gidx_q,  gidx_d;
    logic [IW-1:0]   rr_q,    rr_d;

    logic [IW-1:0]   rr_next;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic            req_g;
    logic [CW-1:0]   len_g;
    logic            tick;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req    (bus.req),
        .ptr    (rr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // Request level and length of the currently granted requester.
    always_comb begin
        req_g = 1'b0;
        len_g = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx_q == IW'(i)) begin
                req_g = bus.req[i];
                len_g = bus.len[i*CW +: CW];
            end
        end
    end

    assign rr_next = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

`ifdef COUNTER_ARB_PRESCALE_EN
    localparam int            DW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PRESCALE - 1);

    logic [DW-1:0] div_q, div_d;

    // Divider restarts in LOAD so the first tick lands PRESCALE cycles into RUN.
    always_comb begin
        div_d = div_q;
        tick  = (div_q == DIV_LAST);
        if (state_q == LOAD) begin
            div_d = '0;
        end else if (state_q == RUN) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    // Without the divider PRESCALE has no effect; keep it referenced.
    wire unused_prescale = (PRESCALE != 0);
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        count_d = count_q;
        limit_d = limit_q;
        rr_d    = rr_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOAD;
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                end
            end
            LOAD: begin
                if (!req_g) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = rr_next;
                end else begin
                    limit_d = len_g;
                    count_d = '0;
                    state_d = (len_g == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!req_g) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = rr_next;
                end else if (tick) begin
                    // Stop on the last value rather than wrapping past limit-1.
                    if (count_q == limit_q - 1'b1) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                rr_d    = rr_next;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // done/busy are registered copies of what the next state implies.
        done_d = (state_d == DONE) ? grant_d : '0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            limit_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            limit_q <= limit_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// ---------------------------------------------------------------------------
// tb_counter_arbiter
// Self-checking bench for counter_arbiter (NREQ=4, CW=4, PRESCALE=4).
// Expected grants are queued when requests are driven and popped when the
// DUT grants; latency and counter values come from a small timing model.
// Honours COUNTER_ARB_PRESCALE_EN in its timing model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_arbiter;

    localparam int NREQ     = 4;
    localparam int CW       = 4;
    localparam int PRESCALE = 4;
`ifdef COUNTER_ARB_PRESCALE_EN
    localparam int P = PRESCALE;
`else
    localparam int P = 1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    counter_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

    counter_arbiter #(
        .NREQ     (NREQ),
        .CW       (CW),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] grant;
        int              len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    // Cycles from grant rising to done rising.
    function automatic int exp_lat(input int len);
        return (len == 0) ? 1 : len * P + 1;
    endfunction

    // Counter value k cycles after grant (k>=1).
    function automatic int exp_cnt(input int len, input int k);
        int c;
        if (len == 0 || k < 1) return 0;
        c = (k - 1) / P;
        return (c < len - 1) ? c : len - 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        bus.len[i*CW +: CW] = CW'(v);
    endtask

    task automatic push(input logic [NREQ-1:0] g, input int len);
        exp_t e;
        e.grant = g;
        e.len   = len;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (bus.grant != '0) ok = 1'b1;
            else step();
        end
        if (!ok) check("grant_wait", 32'(ok), 32'd1);
    endtask

    task automatic wait_count(input logic [CW-1:0] v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.count == v) ok = 1'b1;
            else step();
        end
        check("count_wait", 32'(ok), 32'd1);
    endtask

    // Serve one queued transaction: grant, counting, done pulse, return to idle.
    task automatic run_one(input bit drop);
        exp_t e;
        bit   ok;
        bit   seen;
        wait_grant(ok);
        if (!ok) return;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("grant", 32'(bus.grant), 32'(e.grant));
        check("busy_run", 32'(bus.busy), 32'd1);
        seen = 1'b0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            step();
            check("count", 32'(bus.count), 32'(exp_cnt(e.len, k)));
            if (bus.done != '0) begin
                seen = 1'b1;
                check("done", 32'(bus.done), 32'(e.grant));
                check("latency", 32'(k), 32'(exp_lat(e.len)));
                check("grant_in_done", 32'(bus.grant), 32'(e.grant));
                if (drop) bus.req = bus.req & ~e.grant;
            end else if (bus.grant != e.grant) begin
                check("grant_held", 32'(bus.grant), 32'(e.grant));
                break;
            end
        end
        if (!seen) check("done_wait", 32'(seen), 32'd1);
        step();
        check("done_width", 32'(bus.done), 32'd0);
        check("grant_after_done", 32'(bus.grant), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        bit ok;
        bus.req = '0;
        bus.len = '0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Single requester, len 5
        set_len(1, 5);
        bus.req = 4'b0010;
        push(4'b0010, 5);
        run_one(1'b1);

        // Reset mid-run clears everything immediately, including rr pointer
        set_len(3, 10);
        bus.req = 4'b1000;
        wait_grant(ok);
        check("mid_grant", 32'(bus.grant), 32'h8);
        wait_count(CW'(3));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_grant", 32'(bus.grant), 32'd0);
        check("mid_rst_done",  32'(bus.done),  32'd0);
        check("mid_rst_busy",  32'(bus.busy),  32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        bus.req = '0;
        step();
        reset = 1'b1;
        step();

        // All four requesting, served in round-robin order
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        bus.req = 4'b1111;
        push(4'b0001, 2);
        push(4'b0010, 2);
        push(4'b0100, 2);
        push(4'b1000, 2);
        for (int i = 0; i < NREQ; i++) run_one(1'b1);

        // Pointer wrapped to 0; a requester left high re-queues behind others
        set_len(0, 1);
        set_len(1, 1);
        bus.req = 4'b0011;
        push(4'b0001, 1);
        push(4'b0010, 1);
        push(4'b0001, 1);
        run_one(1'b0);
        run_one(1'b1);
        run_one(1'b1);

        // Abort mid-run: no done, pointer moves past the aborted requester
        set_len(2, 10);
        bus.req = 4'b0100;
        wait_grant(ok);
        check("abort_grant", 32'(bus.grant), 32'h4);
        wait_count(CW'(3));
        bus.req = '0;
        step();
        check("abort_grant_clr", 32'(bus.grant), 32'd0);
        check("abort_done",      32'(bus.done),  32'd0);
        check("abort_busy",      32'(bus.busy),  32'd0);
        step();
        check("abort_done_late", 32'(bus.done),  32'd0);
        set_len(2, 1);
        set_len(3, 1);
        bus.req = 4'b1100;
        push(4'b1000, 1);
        push(4'b0100, 1);
        run_one(1'b1);
        run_one(1'b1);

        // Zero length: LOAD straight to DONE
        set_len(0, 0);
        bus.req = 4'b0001;
        push(4'b0001, 0);
        run_one(1'b1);

        // Length 3 (stretched by the divider when enabled)
        set_len(1, 3);
        bus.req = 4'b0010;
        push(4'b0010, 3);
        run_one(1'b1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
